// File: rtl/hwpf_multi_stack.sv
// Multi-channel prefetch-candidate stack: NUM_CHANNELS circular LIFOs drained
// through one round-robin arbitrated valid/ready request port.
package drac_pkg;
  typedef logic [39:0] addr_t;
endpackage

// One circular LIFO channel. Push/pop arrive already masked by flush/lock.
module hwpf_stack_chan #(
  parameter int  DEPTH      = 2,
  parameter type addr_t     = drac_pkg::addr_t,
  parameter int  FILTER_DUP = 1,
  parameter int  CNT_W      = 2,
  parameter int  PTR_W      = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  addr_t            val,
  output addr_t            top,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  addr_t            mem [DEPTH];
  logic [PTR_W-1:0] ptr, ptr_inc, ptr_dec, wr_ptr;
  logic             dup, push_ok, full;

  assign ptr_inc = (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + PTR_W'(1);
  assign ptr_dec = (ptr == '0) ? PTR_W'(DEPTH-1) : ptr - PTR_W'(1);
  assign full    = (count == CNT_W'(DEPTH));
  assign top     = mem[ptr];

  // A push matching the live top is redundant unless that top is leaving now.
  assign dup      = (FILTER_DUP != 0) && (count != '0) && (val == top) && !pop;
  assign push_ok  = push && !dup;
  assign wr_ptr   = pop ? ptr : ptr_inc;
  assign overflow = push_ok && !pop && full;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= val;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          ptr <= ptr_inc;
          if (!full) count <= count + CNT_W'(1);
        end
        2'b01: begin
          ptr   <= ptr_dec;
          count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

module hwpf_multi_stack #(
  parameter int  NUM_CHANNELS = 2,
  parameter int  DEPTH        = 2,
  parameter type cpu_addr_t   = drac_pkg::addr_t,
  parameter int  FILTER_DUP   = 1,
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int CNT_W        = $clog2(DEPTH+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          lock_i,
  input  logic                          push_i,
  input  logic [CH_W-1:0]               push_ch_i,
  input  cpu_addr_t                     val_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [CH_W-1:0]               chan_o,
  output cpu_addr_t                     req_o,
  output logic [NUM_CHANNELS*CNT_W-1:0] count_o,
  output logic                          overflow_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_CHANNELS-1:0][CNT_W-1:0] cnt;
  cpu_addr_t                          tops [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]            push_ch, pop_ch, ovf_ch, nonempty;
  logic [CH_W-1:0]                    rr_q, sel;
  logic                               found, pop, ovf_q;

  // Scan from rr upward with wrap; lock masks every channel.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      int j;
      j = int'(rr_q) + i;
      if (j >= NUM_CHANNELS) j = j - NUM_CHANNELS;
      if (!found && nonempty[j] && !lock_i) begin
        found = 1'b1;
        sel   = CH_W'(j);
      end
    end
  end

  assign pop        = found && ready_i;
  assign valid_o    = found;
  assign chan_o     = sel;
  assign req_o      = found ? tops[sel] : '0;
  assign count_o    = cnt;
  assign overflow_o = ovf_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign push_ch[c]  = push_i && !lock_i && !flush_i && (push_ch_i == CH_W'(c));
    assign pop_ch[c]   = pop && !flush_i && (sel == CH_W'(c));
    assign nonempty[c] = (cnt[c] != '0);

    hwpf_stack_chan #(
      .DEPTH      (DEPTH),
      .addr_t     (cpu_addr_t),
      .FILTER_DUP (FILTER_DUP),
      .CNT_W      (CNT_W),
      .PTR_W      (PTR_W)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush    (flush_i),
      .push     (push_ch[c]),
      .pop      (pop_ch[c]),
      .val      (val_i),
      .top      (tops[c]),
      .count    (cnt[c]),
      .overflow (ovf_ch[c])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= |ovf_ch;
      if (flush_i)  rr_q <= '0;
      else if (pop) rr_q <= (sel == CH_W'(NUM_CHANNELS-1)) ? '0 : sel + CH_W'(1);
    end
  end
endmodule

// File: tb/tb_hwpf_multi_stack.sv
// Scoreboard bench for hwpf_multi_stack (2 channels, depth 2, dup filter on).
module tb_hwpf_multi_stack;
  typedef drac_pkg::addr_t addr_t;
  typedef struct {logic ch; addr_t data;} exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni, flush_i, lock_i, push_i, push_ch_i, ready_i;
  addr_t      val_i;
  logic       valid_o, chan_o, overflow_o;
  addr_t      req_o;
  logic [3:0] count_o;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  hwpf_multi_stack #(.NUM_CHANNELS(2), .DEPTH(2), .FILTER_DUP(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .lock_i(lock_i),
    .push_i(push_i), .push_ch_i(push_ch_i), .val_i(val_i), .ready_i(ready_i),
    .valid_o(valid_o), .chan_o(chan_o), .req_o(req_o), .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    flush_i = 0; lock_i = 0; push_i = 0; push_ch_i = 0; val_i = '0; ready_i = 0;
  endtask

  task automatic do_push(input logic ch, input addr_t v);
    push_i = 1; push_ch_i = ch; val_i = v;
    cyc();
    push_i = 0;
  endtask

  task automatic do_flush();
    flush_i = 1; cyc(); flush_i = 0;
  endtask

  task automatic test_reset();
    idle(); rst_ni = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1; #1;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count got %h exp 0", count_o); end
    tests++; if (overflow_o !== 1'b0 || req_o !== '0) begin fails++; $display("FAIL reset_ovf_req got %b/%h exp 0/0", overflow_o, req_o); end
  endtask

  task automatic test_single_push();
    do_push(0, 40'hCAFE0001);
    sb.push_back('{1'b0, 40'hCAFE0001});
    #1;
    tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", valid_o); end
    tests++; if (count_o[1:0] !== 2'd1) begin fails++; $display("FAIL single_count got %0d exp 1", count_o[1:0]); end
    ready_i = 1;
    for (int k = 0; k < 6 && sb.size() > 0; k++) begin
      #1;
      if (valid_o) begin
        e = sb.pop_front();
        tests++; if (chan_o !== e.ch || req_o !== e.data) begin fails++; $display("FAIL single_pop got %0d:%h exp %0d:%h", chan_o, req_o, e.ch, e.data); end
      end
      cyc();
    end
    ready_i = 0; #1;
    tests++; if (sb.size() != 0 || valid_o !== 1'b0 || count_o !== 4'd0) begin fails++; $display("FAIL single_after got v=%b cnt=%h left=%0d exp 0/0/0", valid_o, count_o, sb.size()); end
  endtask

  task automatic test_lifo_overflow();
    do_push(1, 40'hCAFE0004); #1;
    tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL ovf_push1 got %b exp 0", overflow_o); end
    do_push(1, 40'hCAFE0005); #1;
    tests++; if (overflow_o !== 1'b0 || count_o[3:2] !== 2'd2) begin fails++; $display("FAIL ovf_push2 got %b cnt %0d exp 0 cnt 2", overflow_o, count_o[3:2]); end
    do_push(1, 40'hCAFE0006); #1;
    sb.push_back('{1'b1, 40'hCAFE0006});
    sb.push_back('{1'b1, 40'hCAFE0005});
    tests++; if (overflow_o !== 1'b1 || count_o[3:2] !== 2'd2) begin fails++; $display("FAIL ovf_push3 got %b cnt %0d exp 1 cnt 2", overflow_o, count_o[3:2]); end
    ready_i = 1;
    for (int k = 0; k < 6 && sb.size() > 0; k++) begin
      #1;
      if (k == 1) begin
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL ovf_pulse_len got %b exp 0", overflow_o); end
      end
      if (valid_o) begin
        e = sb.pop_front();
        tests++; if (chan_o !== e.ch || req_o !== e.data) begin fails++; $display("FAIL lifo_order got %0d:%h exp %0d:%h", chan_o, req_o, e.ch, e.data); end
      end
      cyc();
    end
    ready_i = 0; #1;
    tests++; if (sb.size() != 0 || valid_o !== 1'b0) begin fails++; $display("FAIL lifo_drain got v=%b left=%0d exp 0/0", valid_o, sb.size()); end
  endtask

  task automatic test_round_robin();
    do_flush();
    do_push(0, 40'hA1);
    do_push(0, 40'hA2);
    do_push(1, 40'hB1);
    sb.push_back('{1'b0, 40'hA2});
    sb.push_back('{1'b1, 40'hB1});
    sb.push_back('{1'b0, 40'hA1});
    ready_i = 1;
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      #1;
      if (valid_o) begin
        e = sb.pop_front();
        tests++; if (chan_o !== e.ch || req_o !== e.data) begin fails++; $display("FAIL rr_order got %0d:%h exp %0d:%h", chan_o, req_o, e.ch, e.data); end
      end
      cyc();
    end
    ready_i = 0; #1;
    tests++; if (sb.size() != 0 || valid_o !== 1'b0) begin fails++; $display("FAIL rr_drain got v=%b left=%0d exp 0/0", valid_o, sb.size()); end
  endtask

  task automatic test_simultaneous();
    do_flush();
    do_push(0, 40'hCAFE0002);
    ready_i = 1;
    do_push(0, 40'hCAFE0003);
    ready_i = 0; #1;
    tests++; if (req_o !== 40'hCAFE0003 || count_o[1:0] !== 2'd1) begin fails++; $display("FAIL sim_replace got %h cnt %0d exp cafe0003 cnt 1", req_o, count_o[1:0]); end
    do_flush();
    ready_i = 1; cyc(); ready_i = 0; #1;
    tests++; if (count_o !== 4'd0 || valid_o !== 1'b0) begin fails++; $display("FAIL sim_empty_pop got cnt %h v %b exp 0/0", count_o, valid_o); end
    ready_i = 1;
    do_push(1, 40'hCAFE0007);
    ready_i = 0; #1;
    tests++; if (count_o !== 4'b0100 || chan_o !== 1'b1) begin fails++; $display("FAIL sim_push_empty got cnt %h ch %0d exp 4 ch 1", count_o, chan_o); end
  endtask

  task automatic test_dup_filter();
    do_flush();
    do_push(0, 40'h100); #1;
    tests++; if (count_o[1:0] !== 2'd1) begin fails++; $display("FAIL dup_first got %0d exp 1", count_o[1:0]); end
    do_push(0, 40'h100); #1;
    tests++; if (count_o[1:0] !== 2'd1 || overflow_o !== 1'b0) begin fails++; $display("FAIL dup_drop got %0d ovf %b exp 1 ovf 0", count_o[1:0], overflow_o); end
    do_push(0, 40'h200); #1;
    tests++; if (count_o[1:0] !== 2'd2 || req_o !== 40'h200) begin fails++; $display("FAIL dup_new got %0d %h exp 2 200", count_o[1:0], req_o); end
    do_push(1, 40'h100);
    sb.push_back('{1'b0, 40'h200});
    sb.push_back('{1'b1, 40'h100});
    sb.push_back('{1'b0, 40'h100});
    ready_i = 1;
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      #1;
      if (valid_o) begin
        e = sb.pop_front();
        tests++; if (chan_o !== e.ch || req_o !== e.data) begin fails++; $display("FAIL dup_drain got %0d:%h exp %0d:%h", chan_o, req_o, e.ch, e.data); end
      end
      cyc();
    end
    ready_i = 0; #1;
    tests++; if (sb.size() != 0 || valid_o !== 1'b0) begin fails++; $display("FAIL dup_empty got v=%b left=%0d exp 0/0", valid_o, sb.size()); end
  endtask

  task automatic test_flush_lock();
    do_flush();
    do_push(0, 40'h55);
    lock_i = 1; #1;
    tests++; if (valid_o !== 1'b0 || req_o !== '0) begin fails++; $display("FAIL lock_mask got v=%b req=%h exp 0/0", valid_o, req_o); end
    ready_i = 1;
    do_push(0, 40'h66);
    ready_i = 0; #1;
    tests++; if (count_o !== 4'b0001) begin fails++; $display("FAIL lock_hold got %h exp 1", count_o); end
    lock_i = 0; #1;
    tests++; if (valid_o !== 1'b1 || req_o !== 40'h55) begin fails++; $display("FAIL unlock got v=%b req=%h exp 1/55", valid_o, req_o); end
    flush_i = 1;
    do_push(1, 40'h77);
    flush_i = 0; #1;
    tests++; if (count_o !== 4'd0 || valid_o !== 1'b0) begin fails++; $display("FAIL flush_push got cnt %h v %b exp 0/0", count_o, valid_o); end
  endtask

  task automatic test_async_reset();
    do_push(0, 40'h88);
    do_push(1, 40'h91);
    do_push(1, 40'h92);
    do_push(1, 40'h93);
    #1;
    tests++; if (overflow_o !== 1'b1 || valid_o !== 1'b1) begin fails++; $display("FAIL areset_pre got ovf %b v %b exp 1/1", overflow_o, valid_o); end
    #1 rst_ni = 0; #1;
    tests++; if (valid_o !== 1'b0 || chan_o !== 1'b0 || req_o !== '0 || count_o !== 4'd0 || overflow_o !== 1'b0)
      begin fails++; $display("FAIL areset got v%b c%b r%h n%h o%b exp all 0", valid_o, chan_o, req_o, count_o, overflow_o); end
    cyc(); rst_ni = 1; cyc();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_lifo_overflow();
    test_round_robin();
    test_simultaneous();
    test_dup_filter();
    test_flush_lock();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hwpf_multi_stack.md
# hwpf_multi_stack

Multi-channel, parametrised successor to the single prefetch-candidate stack. It holds NUM_CHANNELS independent circular LIFOs, for example one per load stream or PC slot, each DEPTH entries deep. It drains them through one arbitrated valid/ready request port toward the prefetch issue logic. New features are channel-addressed push, round-robin output arbitration with backpressure, optional duplicate-push filtering, per-channel occupancy and an overflow indication.

## Interface
Parameters:
- NUM_CHANNELS, default 2: number of independent stacks; must be ≥1.
- DEPTH, default 2: entries per channel; must be ≥1.
- cpu_addr_t, default drac_pkg::addr_t: type of a stored entry.
- FILTER_DUP, default 1: when 1, a push equal to the current top of its target channel is dropped.
- Derived: CH_W = max(1, $clog2(NUM_CHANNELS)); CNT_W = $clog2(DEPTH+1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  empties every channel.
- lock_i  in  1  freezes all state and masks the output.
- push_i  in  1  push request.
- push_ch_i  in  CH_W  target channel of the push.
- val_i  in  cpu_addr_t  value to push.
- ready_i  in  1  consumer accepts req_o this cycle.
- valid_o  out  1  req_o/chan_o hold a valid request.
- chan_o  out  CH_W  channel that req_o comes from.
- req_o  out  cpu_addr_t  top entry of the selected channel.
- count_o  out  NUM_CHANNELS*CNT_W  per-channel occupancy; channel c sits at bits [c*CNT_W +: CNT_W].
- overflow_o  out  1  one-cycle registered pulse after a push overwrites an oldest entry.

## Operation
- Per-channel state: DEPTH-entry array, top pointer, count in 0..DEPTH. Pointers wrap modulo DEPTH; non-power-of-2 DEPTH is legal.
- Arbitration is combinational from current state:
  - Start at the rr pointer and scan upward with wrap-around.
  - The first channel with count>0 and lock_i=0 is selected.
  - Outputs: valid_o=1, chan_o = that channel, req_o = its top entry.
  - If no channel is selected: valid_o=0, chan_o=0, req_o=0.
- A pop occurs iff valid_o & ready_i. It pops the selected channel, and rr becomes (selected+1) mod NUM_CHANNELS. With no pop, rr holds.
- Push to channel c, applied after any pop of c in the same cycle:
  - count<DEPTH: top advances, the entry is written, count+1.
  - count==DEPTH: top advances and overwrites the oldest entry, count stays DEPTH, overflow_o pulses next cycle.
  - Simultaneous pop and push on the same channel: the top entry is replaced by val_i and count is unchanged.
  - push_ch_i ≥ NUM_CHANNELS: push ignored.
- Duplicate filter (FILTER_DUP=1): a push is dropped when count(c)>0, val_i equals top(c), and c is not popped this cycle. No state change, no overflow.
- Priority, highest first:
  - rst_ni low: all counts 0, rr=0, overflow_o=0. Array contents need not reset.
  - flush_i: all counts 0, rr=0. Any same-cycle push or pop is discarded.
  - lock_i: push and pop ignored, state held, valid_o forced 0.
  - Normal operation.

## Timing
- Push-to-visibility latency: 1 cycle. A value pushed at edge N drives req_o after edge N, provided its channel is selected.
- Pop takes effect at the edge where valid_o & ready_i is high. The next top, or the next channel, is presented right after that edge.
- overflow_o: high for exactly the one cycle following the overwriting edge.
- count_o: registered; reflects the state after the last edge.
- Reset mid-operation clears all outputs asynchronously: valid_o=0, chan_o=0, req_o=0, count_o=0, overflow_o=0.
- No combinational path from ready_i to valid_o, chan_o or req_o.

## Test plan
All scenarios use NUM_CHANNELS=2, DEPTH=2, FILTER_DUP=1.
- Reset and single push: after reset, valid_o=0 and count_o=0. Push 0xCAFE0001 to ch0 → next cycle valid_o=1, chan_o=0, req_o=0xCAFE0001, count_o[ch0]=1. Pop with ready_i=1 → valid_o=0.
- LIFO order and overflow: push 0xCAFE0004, 0xCAFE0005, 0xCAFE0006 to ch1 on consecutive cycles with ready_i=0 → overflow_o pulses once, after the third push, and count stays 2. Then ready_i=1 → req_o is 0xCAFE0006, then 0xCAFE0005, then valid_o=0.
- Round-robin: ch0 holds 0xA1 and 0xA2 (top), ch1 holds 0xB1, ready_i=1 continuously → serviced order is ch0:0xA2, ch1:0xB1, ch0:0xA1, then valid_o=0.
- Simultaneous events:
  - Push 0xCAFE0003 to ch0 while ch0 is selected and popped → req_o=0xCAFE0003, count unchanged.
  - Push with pop selected on empty channels → count=1.
  - Pop attempt with all channels empty → no change.
- Duplicate filter: ch0 top is 0x100 with ready_i=0. Push 0x100 to ch0 → count unchanged. Push 0x200 → count+1.
- Flush, lock and reset:
  - lock_i=1 with a non-empty channel → valid_o=0, and pushes and pops have no effect.
  - flush_i together with a push → all counts 0 next cycle.
  - rst_ni pulled low between clock edges → all outputs 0 immediately.
